// File: rtl/top2_rr_scheduler.sv
// rtl/top2_rr_scheduler.sv - round-robin shared top-2 tracker; optional out_ready backpressure via TOP2_OUT_READY_EN
module top2_rr_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_CH-1:0]            req_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
    output logic [NUM_CH-1:0]            req_ready,
    input  logic [NUM_CH-1:0]            clr,
    output logic                         out_valid,
    output logic [CH_W-1:0]              out_ch,
    output logic [DATA_WIDTH-1:0]        out_largest,
    output logic [DATA_WIDTH-1:0]        out_second
`ifdef TOP2_OUT_READY_EN
    ,
    input  logic                         out_ready
`endif
);

    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] largest_q [NUM_CH];
    logic [DATA_WIDTH-1:0] largest_d [NUM_CH];
    logic [DATA_WIDTH-1:0] second_q  [NUM_CH];
    logic [DATA_WIDTH-1:0] second_d  [NUM_CH];
    logic                  out_valid_q, out_valid_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic [DATA_WIDTH-1:0] out_largest_q, out_largest_d;
    logic [DATA_WIDTH-1:0] out_second_q, out_second_d;

    logic                  stall;
    logic                  gnt_found;
    logic [CH_W-1:0]       gnt_idx;
    logic [CH_W:0]         cand;
    logic                  fire;
    logic [DATA_WIDTH-1:0] din, base_l, base_s, new_l, new_s;

    // A pending beat that the consumer has not taken freezes the whole engine.
`ifdef TOP2_OUT_READY_EN
    assign stall = out_valid_q && !out_ready;
`else
    assign stall = 1'b0;
`endif

    // Search for the first valid channel at or after the pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
            if (!gnt_found && req_valid[cand[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[CH_W-1:0];
            end
        end
    end

    assign fire = gnt_found && !stall;

    // One-hot grant to the selected channel.
    always_comb begin
        req_ready = '0;
        if (fire) req_ready[gnt_idx] = 1'b1;
    end

    // Top-2 update of the granted channel; a same-cycle clear is applied first.
    always_comb begin
        din    = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        base_l = clr[gnt_idx] ? '0 : largest_q[gnt_idx];
        base_s = clr[gnt_idx] ? '0 : second_q[gnt_idx];
        new_l  = base_l;
        new_s  = base_s;
        if (din > base_l) begin
            new_l = din;
            new_s = base_l;
        end else if (din >= base_s) begin
            new_s = din;
        end
    end

    // Bank next state: clears everywhere, the update only on the granted channel.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            largest_d[k] = clr[k] ? '0 : largest_q[k];
            second_d[k]  = clr[k] ? '0 : second_q[k];
            if (fire && gnt_idx == CH_W'(k)) begin
                largest_d[k] = new_l;
                second_d[k]  = new_s;
            end
        end
    end

    // Pointer advances past the granted channel; output beat follows the grant.
    always_comb begin
        ptr_d         = ptr_q;
        out_valid_d   = fire;
        out_ch_d      = out_ch_q;
        out_largest_d = out_largest_q;
        out_second_d  = out_second_q;
        if (stall) begin
            out_valid_d = out_valid_q;
        end else if (fire) begin
            ptr_d         = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
            out_ch_d      = gnt_idx;
            out_largest_d = new_l;
            out_second_d  = new_s;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q         <= '0;
            out_valid_q   <= 1'b0;
            out_ch_q      <= '0;
            out_largest_q <= '0;
            out_second_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                largest_q[k] <= '0;
                second_q[k]  <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            out_valid_q   <= out_valid_d;
            out_ch_q      <= out_ch_d;
            out_largest_q <= out_largest_d;
            out_second_q  <= out_second_d;
            for (int k = 0; k < NUM_CH; k++) begin
                largest_q[k] <= largest_d[k];
                second_q[k]  <= second_d[k];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_ch      = out_ch_q;
    assign out_largest = out_largest_q;
    assign out_second  = out_second_q;

endmodule

// File: tb/tb_top2_rr_scheduler.sv
// tb/tb_top2_rr_scheduler.sv - scoreboard bench for top2_rr_scheduler
module tb_top2_rr_scheduler;
    localparam int DW = 8;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [NC-1:0]   req_valid, req_ready, clr;
    logic [NC*DW-1:0] req_data;
    logic            out_valid;
    logic [1:0]      out_ch;
    logic [DW-1:0]   out_largest, out_second;
`ifdef TOP2_OUT_READY_EN
    logic            out_ready = 1'b1;
`endif

    always #5 clk = ~clk;

    top2_rr_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .clr(clr), .out_valid(out_valid), .out_ch(out_ch),
        .out_largest(out_largest), .out_second(out_second)
`ifdef TOP2_OUT_READY_EN
        , .out_ready(out_ready)
`endif
    );

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] l;
        logic [7:0] s;
    } beat_t;

    beat_t      sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_l[NC];
    logic [7:0] m_s[NC];
    logic [1:0] m_ptr;
    logic       m_ov;

    function automatic logic [31:0] pack(input int b0, input int b1, input int b2, input int b3);
        return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_l[k] = 0;
            m_s[k] = 0;
        end
        m_ptr = 0;
        m_ov  = 0;
        sb.delete();
    endtask

    // One clock: drive at negedge, model the grant, push the expected beat, sample after posedge.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] c,
                         output logic [3:0] rdy, output logic [3:0] eg,
                         output logic ov, output beat_t ob);
        logic       stall;
        logic [7:0] din;
        int         k;
        req_valid = v;
        req_data  = d;
        clr       = c;
        #1;
        rdy   = req_ready;
        stall = 1'b0;
`ifdef TOP2_OUT_READY_EN
        stall = m_ov && !out_ready;
`endif
        eg = 4'b0000;
        k  = -1;
        if (!stall) begin
            for (int i = 0; i < NC; i++) begin
                int idx;
                idx = (int'(m_ptr) + i) % NC;
                if (k < 0 && v[idx]) k = idx;
            end
        end
        for (int j = 0; j < NC; j++) begin
            if (c[j]) begin
                m_l[j] = 0;
                m_s[j] = 0;
            end
        end
        if (k >= 0) begin
            eg[k] = 1'b1;
            din = d[k*8 +: 8];
            if (din > m_l[k]) begin
                m_s[k] = m_l[k];
                m_l[k] = din;
            end else if (din >= m_s[k]) begin
                m_s[k] = din;
            end
            sb.push_back({2'(k), m_l[k], m_s[k]});
            m_ptr = 2'(k + 1);
            m_ov  = 1'b1;
        end else if (!stall) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        ov = out_valid;
        ob = {out_ch, out_largest, out_second};
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = '0; req_data = '0; clr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_largest !== 8'd0 || out_second !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_out: got v=%0b ch=%0d L=%0d S=%0d want all 0", out_valid, out_ch, out_largest, out_second);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_idle_ready: got %b want 0000", req_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_rr_all();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob, e;
        logic [3:0] want[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, pack(10, 20, 30, 40), 4'b0000, rdy, eg, ov, ob);
            n_cmp++;
            if (rdy !== want[i]) begin
                n_bad++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, rdy, want[i]);
            end
            e = sb.pop_front();
            n_cmp++;
            if (ov !== 1'b1 || ob !== e) begin
                n_bad++;
                $display("FAIL rr_beat[%0d]: got v=%0b %h want v=1 %h", i, ov, ob, e);
            end
        end
    endtask

    task automatic test_ch2_seq();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob;
        int seq[5] = '{5, 9, 7, 9, 3};
        int wl[5]  = '{5, 9, 9, 9, 9};
        int ws[5]  = '{0, 5, 7, 9, 9};
        cycle(4'b0000, '0, 4'b0100, rdy, eg, ov, ob);
        n_cmp++;
        if (ov !== 1'b0 || rdy !== 4'b0000) begin
            n_bad++;
            $display("FAIL ch2_clr_cycle: got v=%0b rdy=%b want v=0 rdy=0000", ov, rdy);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0100, pack(0, 0, seq[i], 0), 4'b0000, rdy, eg, ov, ob);
            void'(sb.pop_front());
            n_cmp++;
            if (ov !== 1'b1 || ob !== {2'd2, 8'(wl[i]), 8'(ws[i])}) begin
                n_bad++;
                $display("FAIL ch2_seq[%0d]: got v=%0b ch=%0d L=%0d S=%0d want v=1 ch=2 L=%0d S=%0d",
                         i, ov, ob.ch, ob.l, ob.s, wl[i], ws[i]);
            end
        end
        cycle(4'b0000, '0, 4'b0000, rdy, eg, ov, ob);
        n_cmp++;
        if (ov !== 1'b0 || ob !== {2'd2, 8'd9, 8'd9}) begin
            n_bad++;
            $display("FAIL idle_hold: got v=%0b %h want v=0 %h", ov, ob, {2'd2, 8'd9, 8'd9});
        end
    endtask

    task automatic test_clr_collide();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob, e;
        logic [3:0]  tv[7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        logic [31:0] td[7] = '{32'h0, pack(0, 9, 0, 0), pack(0, 5, 0, 0), pack(7, 0, 0, 0),
                               pack(0, 4, 0, 0), pack(1, 0, 0, 0), pack(0, 6, 0, 0)};
        logic [3:0]  tc[7] = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
        beat_t       tw[7] = '{18'h0, {2'd1, 8'd9, 8'd0}, {2'd1, 8'd9, 8'd5}, {2'd0, 8'd7, 8'd0},
                               {2'd1, 8'd4, 8'd0}, {2'd0, 8'd7, 8'd1}, {2'd1, 8'd6, 8'd4}};
        for (int i = 0; i < 7; i++) begin
            cycle(tv[i], td[i], tc[i], rdy, eg, ov, ob);
            if (tv[i] == 4'b0000) begin
                n_cmp++;
                if (ov !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clr_idle[%0d]: got v=%0b want 0", i, ov);
                end
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if (ov !== 1'b1 || ob !== tw[i] || e !== tw[i]) begin
                    n_bad++;
                    $display("FAIL clr_beat[%0d]: got v=%0b %h want v=1 %h", i, ov, ob, tw[i]);
                end
            end
        end
    endtask

    task automatic test_ptr_wrap();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob, e;
        logic [3:0] tv[4] = '{4'b0001, 4'b1001, 4'b1001, 4'b1111};
        logic [3:0] tw[4] = '{4'b0001, 4'b1000, 4'b0001, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            cycle(tv[i], pack(3, 3, 3, 3), 4'b0000, rdy, eg, ov, ob);
            n_cmp++;
            if (rdy !== tw[i]) begin
                n_bad++;
                $display("FAIL ptr_grant[%0d]: got %b want %b", i, rdy, tw[i]);
            end
            e = sb.pop_front();
            n_cmp++;
            if (ov !== 1'b1 || ob !== e) begin
                n_bad++;
                $display("FAIL ptr_beat[%0d]: got v=%0b %h want v=1 %h", i, ov, ob, e);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  rdy, eg, v, c;
        logic [31:0] d;
        logic        ov;
        beat_t       ob, e, last;
        last = {out_ch, out_largest, out_second};
        for (int i = 0; i < 60; i++) begin
            v = 4'($urandom_range(0, 15));
            c = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            for (int b = 0; b < 4; b++) d[b*8 +: 8] = 8'($urandom_range(0, 15));
            cycle(v, d, c, rdy, eg, ov, ob);
            n_cmp++;
            if (rdy !== eg) begin
                n_bad++;
                $display("FAIL rand_grant[%0d]: got %b want %b", i, rdy, eg);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                last = e;
                n_cmp++;
                if (ov !== 1'b1 || ob !== e) begin
                    n_bad++;
                    $display("FAIL rand_beat[%0d]: got v=%0b %h want v=1 %h", i, ov, ob, e);
                end
            end else begin
                n_cmp++;
                if (ov !== 1'b0 || ob !== last) begin
                    n_bad++;
                    $display("FAIL rand_idle[%0d]: got v=%0b %h want v=0 %h", i, ov, ob, last);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob;
        cycle(4'b0010, pack(0, 200, 0, 0), 4'b0000, rdy, eg, ov, ob);
        sb.delete();
        resetn = 1'b0; req_valid = 4'b0100; req_data = pack(0, 0, 77, 0); clr = '0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_largest !== 8'd0 || out_ch !== 2'd0) begin
            n_bad++;
            $display("FAIL midreset_out: got v=%0b ch=%0d L=%0d want 0/0/0", out_valid, out_ch, out_largest);
        end
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        cycle(4'b1111, pack(1, 2, 3, 4), 4'b0000, rdy, eg, ov, ob);
        void'(sb.pop_front());
        n_cmp++;
        if (rdy !== 4'b0001 || ov !== 1'b1 || ob !== {2'd0, 8'd1, 8'd0}) begin
            n_bad++;
            $display("FAIL midreset_ptr: got rdy=%b v=%0b %h want rdy=0001 v=1 %h", rdy, ov, ob, {2'd0, 8'd1, 8'd0});
        end
        cycle(4'b0010, pack(0, 2, 0, 0), 4'b0000, rdy, eg, ov, ob);
        void'(sb.pop_front());
        n_cmp++;
        if (ov !== 1'b1 || ob !== {2'd1, 8'd2, 8'd0}) begin
            n_bad++;
            $display("FAIL midreset_state: got v=%0b %h want v=1 %h", ov, ob, {2'd1, 8'd2, 8'd0});
        end
    endtask

`ifdef TOP2_OUT_READY_EN
    task automatic test_out_ready();
        logic [3:0] rdy, eg;
        logic       ov;
        beat_t      ob, held, e;
        out_ready = 1'b1;
        cycle(4'b0001, pack(50, 60, 0, 0), 4'b0000, rdy, eg, ov, ob);
        held = sb[0];
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, pack(50, 60, 0, 0), 4'b0000, rdy, eg, ov, ob);
            n_cmp++;
            if (rdy !== 4'b0000 || ov !== 1'b1 || ob !== held) begin
                n_bad++;
                $display("FAIL stall[%0d]: got rdy=%b v=%0b %h want rdy=0000 v=1 %h", i, rdy, ov, ob, held);
            end
        end
        out_ready = 1'b1;
        cycle(4'b1111, pack(50, 60, 0, 0), 4'b0000, rdy, eg, ov, ob);
        void'(sb.pop_front());
        e = sb.pop_front();
        n_cmp++;
        if (rdy !== 4'b0010 || ov !== 1'b1 || ob !== e) begin
            n_bad++;
            $display("FAIL stall_release: got rdy=%b v=%0b %h want rdy=0010 v=1 %h", rdy, ov, ob, e);
        end
    endtask
`endif

    initial begin
        resetn = 1'b0; req_valid = '0; req_data = '0; clr = '0;
        @(negedge clk);
        test_reset();
        test_rr_all();
        test_ch2_seq();
        test_clr_collide();
        test_ptr_wrap();
        test_random();
        test_reset_midstream();
`ifdef TOP2_OUT_READY_EN
        test_out_ready();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish within budget want finish");
        $fatal(1, "timeout");
    end

endmodule
